// File: rtl/centroid_div3_seq_if.sv
// Handshake bundle for the centroid divide-by-3 stage.
// master drives sums and out_ready; slave is the divider.
interface centroid_div3_seq_if #(
    parameter int N = 8
);
    localparam int W = N + 4;

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] xM;
    logic signed [W-1:0] yM;
    logic                out_valid;
    logic                out_ready;
    logic signed [N+1:0] xC;
    logic signed [N+1:0] yC;
    logic signed [2:0]   xR;
    logic signed [2:0]   yR;

    modport master (
        output in_valid, xM, yM, out_ready,
        input  in_ready, out_valid, xC, yC, xR, yR
    );

    modport slave (
        input  in_valid, xM, yM, out_ready,
        output in_ready, out_valid, xC, yC, xR, yR
    );
endinterface

// File: rtl/centroid_div3_seq.sv
// Sequential signed divide-by-3 of the median sums, x/y lanes in parallel.
// Define CENTROID_ROUND_NEAREST_EN to round the quotient to nearest.
module centroid_div3_seq #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    centroid_div3_seq_if.slave bus
);
    localparam int W  = N + 4;
    localparam int CW = $clog2(W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic                xs, ys;
    logic [W-1:0]        xmag, ymag;
    logic [1:0]          xrem, yrem;
    logic [N+1:1]        xq, yq;
    logic signed [N+1:0] xc, yc;
    logic signed [2:0]   xr, yr;

    logic [2:0]   xsh, ysh, xnr, ynr;
    logic         xge, yge;
    logic [N+1:0] xqf, yqf;

    // Partial remainder never exceeds 2, so two stored bits suffice.
    always_comb begin
        xsh = {xrem, xmag[W-1]};
        ysh = {yrem, ymag[W-1]};
        xge = (xsh >= 3'd3);
        yge = (ysh >= 3'd3);
        xnr = xge ? xsh - 3'd3 : xsh;
        ynr = yge ? ysh - 3'd3 : ysh;
        xqf = {xq, xge};
        yqf = {yq, yge};
`ifdef CENTROID_ROUND_NEAREST_EN
        if (xnr == 3'd2) xqf = xqf + (N+2)'(1);
        if (ynr == 3'd2) yqf = yqf + (N+2)'(1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            xs    <= 1'b0;
            ys    <= 1'b0;
            xmag  <= '0;
            ymag  <= '0;
            xrem  <= '0;
            yrem  <= '0;
            xq    <= '0;
            yq    <= '0;
            xc    <= '0;
            yc    <= '0;
            xr    <= '0;
            yr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xs    <= bus.xM[W-1];
                        ys    <= bus.yM[W-1];
                        xmag  <= bus.xM[W-1] ? -bus.xM : bus.xM;
                        ymag  <= bus.yM[W-1] ? -bus.yM : bus.yM;
                        xrem  <= '0;
                        yrem  <= '0;
                        xq    <= '0;
                        yq    <= '0;
                        cnt   <= CW'(W - 1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    xmag <= xmag << 1;
                    ymag <= ymag << 1;
                    xrem <= xnr[1:0];
                    yrem <= ynr[1:0];
                    // Only the low N+2 quotient bits are kept (wrap).
                    for (int i = 1; i <= N + 1; i++) begin
                        if (cnt == CW'(i)) begin
                            xq[i] <= xge;
                            yq[i] <= yge;
                        end
                    end
                    if (cnt == '0) begin
                        xc    <= xs ? -xqf : xqf;
                        yc    <= ys ? -yqf : yqf;
                        xr    <= xs ? -xnr : xnr;
                        yr    <= ys ? -ynr : ynr;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.xC        = xc;
    assign bus.yC        = yc;
    assign bus.xR        = xr;
    assign bus.yR        = yr;
endmodule

// File: tb/tb_centroid_div3_seq.sv
// Scoreboard bench for centroid_div3_seq (N=8, W=12).
module tb_centroid_div3_seq;
    localparam int N = 8;
    localparam int W = N + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    centroid_div3_seq_if #(.N(N)) bus ();

    centroid_div3_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int xc;
        int yc;
        int xr;
        int yr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc = 0;
    int   gap = 0;
    logic prev_ov = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int quo(input int v);
        int q;
        logic signed [N+1:0] t;
        q = v / 3;
`ifdef CENTROID_ROUND_NEAREST_EN
        if (v % 3 == 2 || v % 3 == -2) q = (v < 0) ? q - 1 : q + 1;
`endif
        t = q[N+1:0];
        return int'(t);
    endfunction

    // Expected result is queued on the accepting edge.
    always @(posedge clk) begin
        if (!rst) begin
            cyc++;
            if (bus.in_valid && bus.in_ready) begin
                gap = cyc - acc;
                acc = cyc;
                sb.push_back('{quo(int'(bus.xM)), quo(int'(bus.yM)),
                               int'(bus.xM) % 3, int'(bus.yM) % 3});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) check("latency", cyc - acc, 12);
            prev_ov = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("xC", int'(bus.xC), e.xc);
                    check("yC", int'(bus.yC), e.yc);
                    check("xR", int'(bus.xR), e.xr);
                    check("yR", int'(bus.yR), e.yr);
                end
            end
        end
    end

    task automatic send(input int x, input int y);
        int n = 0;
        bus.xM       = W'(x);
        bus.yM       = W'(y);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int bx[3];
        int n;
        bx = '{45, -999, 1001};
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.xM        = '0;
        bus.yM        = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_xC", int'(bus.xC), 0);
        check("rst_yC", int'(bus.yC), 0);
        check("rst_xR", int'(bus.xR), 0);
        check("rst_yR", int'(bus.yR), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send(300, -300);   drain();
        send(8, -8);       drain();
        send(-1536, 1533); drain();
        send(-1, 1);       drain();
        send(0, 3);        drain();
        for (int i = 0; i < 4; i++) begin
            send(int'($urandom_range(3069)) - 1536,
                 int'($urandom_range(3069)) - 1536);
            drain();
        end

        // Backpressure: result held, new request must wait.
        bus.out_ready = 1'b0;
        send(123, -45);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_wait", int'(bus.out_valid), 1);
        bus.xM       = W'(600);
        bus.yM       = W'(7);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", int'(bus.out_valid), 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
            if (sb.size() != 1) begin
                check("bp_sb", sb.size(), 1);
            end else begin
                check("bp_xC", int'(bus.xC), sb[0].xc);
                check("bp_yC", int'(bus.yC), sb[0].yc);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_accept", acc, cyc);
        drain();

        // Asynchronous reset in the middle of CALC.
        send(500, -200);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ab_out_valid", int'(bus.out_valid), 0);
        check("ab_in_ready", int'(bus.in_ready), 1);
        check("ab_xC", int'(bus.xC), 0);
        check("ab_yC", int'(bus.yC), 0);
        check("ab_xR", int'(bus.xR), 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(9, 0);
        drain();

        // Back-to-back with in_valid kept high.
        for (int i = 0; i < 3; i++) begin
            send(bx[i], -bx[i] + 2);
            if (i > 0) check("gap", gap, 14);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
